// File: rtl/btb_pkg.sv
// rtl/btb_pkg.sv - shared types, counter encodings and tag helper for the branch target buffer
package btb_pkg;

    localparam int BTB_PC_W = 32;
    localparam int TAG_W    = BTB_PC_W - 2;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } btb_state_e;

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [BTB_PC_W-1:0] target;
        logic [1:0]          ctr;
    } btb_entry_t;

    typedef struct packed {
        logic                alloc;
        logic [BTB_PC_W-1:0] pc;
        logic [BTB_PC_W-1:0] target;
        logic                taken;
    } btb_req_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [BTB_PC_W-1:0] pc);
        return pc[BTB_PC_W-1:2];
    endfunction

endpackage

// File: rtl/btb_sat_ctr.sv
// rtl/btb_sat_ctr.sv - next value of a 2-bit direction counter for allocate or train
module btb_sat_ctr
    import btb_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       alloc_i,
    input  logic       taken_i,
    output logic [1:0] ctr_o
);

    always_comb begin
        ctr_o = ctr_i;
        if (alloc_i) begin
            ctr_o = taken_i ? WT : WNT;
        end else if (taken_i) begin
            if (ctr_i != ST) ctr_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/btb_ctrl.sv
// rtl/btb_ctrl.sv - fully associative BTB with stall-tolerant update buffer and flush sweep
// Optional BTB_BYPASS_EN: forward a same-cycle commit to the fetch lookup.
module btb_ctrl
    import btb_pkg::*;
#(
    parameter int ENTRIES = 8,
    parameter int PC_W    = BTB_PC_W,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] if_pc,
    output logic            hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] pred_target,
    input  logic            upd_valid,
    input  logic            upd_alloc,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            pipe_stall,
    input  logic            flush_req,
    output logic            flush_busy,
    output logic            pend_ovf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    btb_entry_t       entries_q [ENTRIES];
    btb_state_e       state_q, state_d;
    logic [IDX_W-1:0] flush_idx_q, victim_q;
    logic             pend_valid_q, pend_ovf_q;
    btb_req_t         pend_q;

    btb_req_t         new_req, cm_req;
    btb_entry_t       cm_entry;
    logic             can_commit, cm_valid, cm_hit, cm_we, lk_hit;
    logic [IDX_W-1:0] cm_idx, cm_widx, lk_idx;
    logic [1:0]       cm_ctr;
    logic             unused_pc_lsbs;

    assign can_commit     = (state_q == RUN) && !pipe_stall;
    assign new_req        = '{alloc: upd_alloc, pc: upd_pc, target: upd_target, taken: upd_taken};
    assign cm_valid       = can_commit && (pend_valid_q || upd_valid);
    assign cm_req         = pend_valid_q ? pend_q : new_req;
    assign unused_pc_lsbs = ^{if_pc[1:0], cm_req.pc[1:0]};

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        cm_hit = 1'b0;
        cm_idx = '0;
        lk_hit = 1'b0;
        lk_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (entries_q[i].valid && entries_q[i].tag == pc_tag(cm_req.pc)) begin
                cm_hit = 1'b1;
                cm_idx = IDX_W'(i);
            end
            if (entries_q[i].valid && entries_q[i].tag == pc_tag(if_pc)) begin
                lk_hit = 1'b1;
                lk_idx = IDX_W'(i);
            end
        end
    end

    btb_sat_ctr u_sat_ctr (
        .ctr_i   (entries_q[cm_idx].ctr),
        .alloc_i (cm_req.alloc),
        .taken_i (cm_req.taken),
        .ctr_o   (cm_ctr)
    );

    // A train that misses writes nothing.
    always_comb begin
        cm_we    = cm_valid && (cm_req.alloc || cm_hit);
        cm_widx  = (cm_req.alloc && !cm_hit) ? victim_q : cm_idx;
        cm_entry = '{valid:  1'b1,
                     tag:    pc_tag(cm_req.pc),
                     target: cm_req.alloc ? cm_req.target : entries_q[cm_idx].target,
                     ctr:    cm_ctr};
    end

    always_comb begin
        hit         = 1'b0;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (state_q == RUN) begin
            if (lk_hit) begin
                hit         = 1'b1;
                pred_taken  = entries_q[lk_idx].ctr[1];
                pred_target = entries_q[lk_idx].target;
            end
`ifdef BTB_BYPASS_EN
            if (cm_we && cm_entry.tag == pc_tag(if_pc)) begin
                hit         = 1'b1;
                pred_taken  = cm_entry.ctr[1];
                pred_target = cm_entry.target;
            end
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (flush_req) state_d = FLUSH;
            FLUSH:   if (flush_idx_q == LAST_IDX) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign flush_busy = (state_q == FLUSH);
    assign pend_ovf   = pend_ovf_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= RUN;
            flush_idx_q  <= '0;
            victim_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            pend_ovf_q   <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == FLUSH) begin
                entries_q[flush_idx_q].valid <= 1'b0;
                flush_idx_q                  <= flush_idx_q + IDX_W'(1);
                if (flush_idx_q == LAST_IDX) victim_q <= '0;
            end
            if (cm_we) begin
                entries_q[cm_widx] <= cm_entry;
                if (cm_req.alloc && !cm_hit) victim_q <= victim_q + IDX_W'(1);
            end
            // A full buffer that drains this cycle hands its slot to the new request.
            if (upd_valid && (pend_valid_q ? can_commit : !can_commit)) begin
                pend_valid_q <= 1'b1;
                pend_q       <= new_req;
            end else if (pend_valid_q && can_commit) begin
                pend_valid_q <= 1'b0;
            end
            if (upd_valid && pend_valid_q && !can_commit) pend_ovf_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_btb_ctrl.sv
// tb/tb_btb_ctrl.sv - randomized and directed bench for btb_ctrl against a behavioural model
module tb_btb_ctrl;

    localparam int N = 8;
`ifdef BTB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        alloc;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        taken;
    } req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc, upd_pc, upd_target, pred_target;
    logic        hit, pred_taken, upd_valid, upd_alloc, upd_taken;
    logic        pipe_stall, flush_req, flush_busy, pend_ovf;

    always #5 clk = ~clk;

    btb_ctrl #(.ENTRIES(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .if_pc       (if_pc),
        .hit         (hit),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .upd_valid   (upd_valid),
        .upd_alloc   (upd_alloc),
        .upd_pc      (upd_pc),
        .upd_target  (upd_target),
        .upd_taken   (upd_taken),
        .pipe_stall  (pipe_stall),
        .flush_req   (flush_req),
        .flush_busy  (flush_busy),
        .pend_ovf    (pend_ovf)
    );

    bit          m_v   [N];
    logic [29:0] m_tag [N];
    logic [31:0] m_tgt [N];
    int          m_ctr [N];
    int          m_vic, m_fidx;
    bit          m_flush, m_ovf;
    req_t        m_pend[$];
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int find(input logic [31:0] pc);
        for (int i = 0; i < N; i++)
            if (m_v[i] && m_tag[i] == pc[31:2]) return i;
        return -1;
    endfunction

    function automatic int trained(input int c, input bit tk);
        if (tk) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_v[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 0;
        end
        m_vic = 0; m_fidx = 0; m_flush = 0; m_ovf = 0;
        m_pend.delete();
    endtask

    task automatic decide(output bit cv, output req_t cr);
        bit can;
        can = !m_flush && !pipe_stall;
        cr  = '{upd_alloc, upd_pc, upd_target, upd_taken};
        cv  = 0;
        if (can && m_pend.size() > 0) begin
            cv = 1;
            cr = m_pend[0];
        end else if (can && upd_valid) begin
            cv = 1;
        end
    endtask

    task automatic apply(input req_t cr);
        int k;
        k = find(cr.pc);
        if (cr.alloc) begin
            if (k < 0) begin
                k = m_vic;
                m_vic = (m_vic + 1) % N;
            end
            m_v[k] = 1; m_tag[k] = cr.pc[31:2]; m_tgt[k] = cr.tgt;
            m_ctr[k] = cr.taken ? 2 : 1;
        end else if (k >= 0) begin
            m_ctr[k] = trained(m_ctr[k], cr.taken);
        end
    endtask

    task automatic model_clock();
        bit cv; req_t cr, nr;
        decide(cv, cr);
        nr = '{upd_alloc, upd_pc, upd_target, upd_taken};
        if (cv && m_pend.size() > 0) begin
            void'(m_pend.pop_front());
            if (upd_valid) m_pend.push_back(nr);
        end else if (!cv && upd_valid) begin
            if (m_pend.size() == 0) m_pend.push_back(nr);
            else m_ovf = 1;
        end
        if (cv) apply(cr);
        if (m_flush) begin
            m_v[m_fidx] = 0;
            if (m_fidx == N - 1) begin
                m_flush = 0; m_fidx = 0; m_vic = 0;
            end else begin
                m_fidx++;
            end
        end else if (flush_req) begin
            m_flush = 1;
        end
    endtask

    task automatic check_outputs();
        int k; bit eh, et; logic [31:0] eg;
`ifdef BTB_BYPASS_EN
        bit cv; req_t cr; int j;
`endif
        k  = m_flush ? -1 : find(if_pc);
        eh = (k >= 0);
        et = eh ? (m_ctr[k] >= 2) : 1'b0;
        eg = eh ? m_tgt[k] : 32'h0;
`ifdef BTB_BYPASS_EN
        decide(cv, cr);
        if (cv && cr.pc[31:2] == if_pc[31:2]) begin
            j = find(cr.pc);
            if (cr.alloc) begin
                eh = 1; eg = cr.tgt; et = cr.taken;
            end else if (j >= 0) begin
                eh = 1; eg = m_tgt[j]; et = (trained(m_ctr[j], cr.taken) >= 2);
            end
        end
`endif
        check("hit", 32'(hit), 32'(eh));
        check("pred_taken", 32'(pred_taken), 32'(et));
        check("pred_target", pred_target, eg);
        check("flush_busy", 32'(flush_busy), 32'(m_flush));
        check("pend_ovf", 32'(pend_ovf), 32'(m_ovf));
    endtask

    task automatic drive(input bit v, input bit a, input logic [31:0] pc, input logic [31:0] tg,
                         input bit tk, input bit st, input bit fl, input logic [31:0] ipc);
        upd_valid = v; upd_alloc = a; upd_pc = pc; upd_target = tg; upd_taken = tk;
        pipe_stall = st; flush_req = fl; if_pc = ipc;
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic probe(input string t, input logic [31:0] ipc, input bit eh, input bit et,
                         input logic [31:0] eg);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, ipc);
        #1;
        check({t, "_hit"}, 32'(hit), 32'(eh));
        check({t, "_taken"}, 32'(pred_taken), 32'(et));
        check({t, "_target"}, pred_target, eg);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h40);
        #1;
        model_reset();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] rpc();
        return 32'h1000 + 32'($urandom_range(0, 11) << 4) + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        reset = 1'b1;
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h40);
        #2;
        do_reset();
        probe("reset", 32'h40, 0, 0, 32'h0);
        check("reset_busy", 32'(flush_busy), 32'h0);
        check("reset_ovf", 32'(pend_ovf), 32'h0);

        // allocate then train down to saturation
        drive(1, 1, 32'h40, 32'h80, 1, 0, 0, 32'h40); tick();
        probe("alloc", 32'h40, 1, 1, 32'h80);
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 32'h40, 32'h0, 0, 0, 0, 32'h40); tick();
        end
        probe("train_sat", 32'h40, 1, 0, 32'h80);
        drive(1, 0, 32'h40, 32'h0, 1, 0, 0, 32'h40); tick();
        probe("train_up", 32'h40, 1, 0, 32'h80);

        // round-robin replacement
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(1, 1, 32'h1000 + 32'(i * 4), 32'h9000 + 32'(i), 1, 0, 0, 32'h0); tick();
        end
        probe("evict0", 32'h1000, 0, 0, 32'h0);
        probe("keep1", 32'h1004, 1, 1, 32'h9001);
        drive(1, 1, 32'h1008, 32'hA008, 0, 0, 0, 32'h0); tick();
        drive(1, 1, 32'h2000, 32'hB000, 1, 0, 0, 32'h0); tick();
        probe("evict1", 32'h1004, 0, 0, 32'h0);
        probe("realloc", 32'h1008, 1, 0, 32'hA008);
        probe("new_at1", 32'h2000, 1, 1, 32'hB000);

        // stall holding and overflow drop
        do_reset();
        drive(1, 1, 32'h100, 32'h500, 1, 1, 0, 32'h100); tick();
        drive(1, 1, 32'h104, 32'h504, 1, 1, 0, 32'h100);
        #1;
        check("stalled_hit", 32'(hit), 32'h0);
        tick();
        check("ovf_set", 32'(pend_ovf), 32'h1);
        drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h100); tick();
        probe("drained", 32'h100, 1, 1, 32'h500);
        probe("dropped", 32'h104, 0, 0, 32'h0);

        // flush sweep
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h300 + 32'(i * 4), 32'h700, 1, 0, 0, 32'h0); tick();
        end
        drive(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h300); tick();
        for (int i = 0; i < N; i++) begin
            probe("sweep", 32'h300, 0, 0, 32'h0);
            check("sweep_busy", 32'(flush_busy), 32'h1);
            flush_req = 1'b1;
            tick();
        end
        check("sweep_done", 32'(flush_busy), 32'h0);
        for (int i = 0; i < 4; i++) probe("flushed", 32'h300 + 32'(i * 4), 0, 0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 32'h300 + 32'(i * 4), 32'h700, 1, 0, 0, 32'h0); tick();
        end
        drive(0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h300); tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h300); tick();
        end
        reset = 1'b0;
        #1;
        check("midflush_reset_busy", 32'(flush_busy), 32'h0);
        do_reset();

        // same-cycle allocate and lookup
        drive(1, 1, 32'h200, 32'h600, 1, 0, 0, 32'h200);
        #1;
        check("samecyc_hit", 32'(hit), 32'(BYP));
        check("samecyc_target", pred_target, BYP ? 32'h600 : 32'h0);
        tick();
        probe("after_samecyc", 32'h200, 1, 1, 32'h600);

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset();
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rpc(), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 39) == 0), rpc());
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
